// File: rtl/alu_arb_pkg.sv
// Shared constants and state type for the alu_arb4 round-robin mux arbiter.
package alu_arb_pkg;
    localparam int N_REQ = 4;
    localparam int SEL_W = 2;
    localparam int CNT_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } arb_state_t;
endpackage

// File: rtl/alu_arb4_rr_pick4.sv
// Combinational round-robin picker: first set request at or after ptr, wrapping mod 4.
module rr_pick4
    import alu_arb_pkg::*;
(
    input  logic [N_REQ-1:0] req,
    input  logic [SEL_W-1:0] ptr,
    output logic [SEL_W-1:0] win_idx,
    output logic             win_vld
);
    logic [SEL_W-1:0] idx;

    // Scan from lowest priority to highest so the last hit (ptr itself) wins.
    always_comb begin
        win_idx = '0;
        win_vld = 1'b0;
        idx     = '0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            idx = ptr + SEL_W'(k);
            if (req[idx]) begin
                win_idx = idx;
                win_vld = 1'b1;
            end
        end
    end
endmodule

// File: rtl/alu_arb4.sv
// Round-robin arbiter/sequencer owning the ALU 4:1 operand mux select.
// Optional back-to-back locked grants are enabled with `define ALU_ARB_LOCK_EN.
module alu_arb4
    import alu_arb_pkg::*;
#(
    parameter int LATENCY = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_REQ-1:0] req,
    input  logic [N_REQ-1:0] lock,
    output logic [N_REQ-1:0] gnt,
    output logic [SEL_W-1:0] sel,
    output logic [N_REQ-1:0] ack,
    output logic             busy
);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(LATENCY - 1);

    arb_state_t       state_q, state_d;
    logic [SEL_W-1:0] ptr_q, ptr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [N_REQ-1:0] gnt_q, gnt_d;
    logic [SEL_W-1:0] sel_q, sel_d;
    logic [N_REQ-1:0] ack_q, ack_d;
    logic             busy_q, busy_d;
    logic [SEL_W-1:0] win_idx;
    logic             win_vld;
    logic [N_REQ-1:0] lock_w;

`ifdef ALU_ARB_LOCK_EN
    assign lock_w = lock;
`else
    assign lock_w = lock & {N_REQ{1'b0}};
`endif

    rr_pick4 u_pick (
        .req     (req),
        .ptr     (ptr_q),
        .win_idx (win_idx),
        .win_vld (win_vld)
    );

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        cnt_d   = cnt_q;
        gnt_d   = gnt_q;
        sel_d   = sel_q;
        ack_d   = '0;
        busy_d  = busy_q;
        case (state_q)
            IDLE: begin
                if (win_vld) begin
                    state_d = BUSY;
                    gnt_d   = N_REQ'(1) << win_idx;
                    sel_d   = win_idx;
                    busy_d  = 1'b1;
                    cnt_d   = CNT_LOAD;
                    ptr_d   = win_idx + SEL_W'(1);
                end
            end
            BUSY: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CNT_W'(1);
                end else begin
                    state_d = DONE;
                    ack_d   = gnt_q;
                end
            end
            DONE: begin
                // A locked owner keeps the mux without re-arbitrating; ptr stays put.
                if (lock_w[sel_q] && req[sel_q]) begin
                    state_d = BUSY;
                    cnt_d   = CNT_LOAD;
                end else begin
                    state_d = IDLE;
                    gnt_d   = '0;
                    busy_d  = 1'b0;
                end
            end
            default: begin
                state_d = IDLE;
                gnt_d   = '0;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            cnt_q   <= '0;
            gnt_q   <= '0;
            sel_q   <= '0;
            ack_q   <= '0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
            gnt_q   <= gnt_d;
            sel_q   <= sel_d;
            ack_q   <= ack_d;
            busy_q  <= busy_d;
        end
    end

    assign gnt  = gnt_q;
    assign sel  = sel_q;
    assign ack  = ack_q;
    assign busy = busy_q;

    a_gnt_onehot: assert property (@(posedge clk) disable iff (rst) $onehot0(gnt_q));
    a_sel_match:  assert property (@(posedge clk) disable iff (rst)
                                   busy_q |-> (gnt_q == (N_REQ'(1) << sel_q)));
    a_ack_subset: assert property (@(posedge clk) disable iff (rst) (ack_q & ~gnt_q) == '0);
endmodule

// File: tb/tb_alu_arb4.sv
// Directed bench for alu_arb4: LATENCY=1 and LATENCY=3 instances checked against a timing model.
module tb_alu_arb4;
    logic       clk, rst;
    logic [3:0] req, lock;
    logic [3:0] gnt0, ack0, gnt3, ack3;
    logic [1:0] sel0, sel3;
    logic       busy0, busy3;

    int n_chk = 0, n_pass = 0, cyc = 0;
    bit mdl_on = 0;
    logic [3:0] prev_ack = '0;
    int ord[$], cq[$];

`ifdef ALU_ARB_LOCK_EN
    localparam bit LOCK = 1'b1;
    localparam int NLK = 3, LK_GAP = 2;
    int exp_lock[3] = '{0, 0, 2};
`else
    localparam bit LOCK = 1'b0;
    localparam int NLK = 2, LK_GAP = 3;
    int exp_lock[2] = '{0, 2};
`endif
    int exp_fair[6] = '{0, 1, 2, 3, 0, 1};
    int exp_wrap[3] = '{1, 3, 1};

    alu_arb4 #(.LATENCY(1)) u_dut1 (.clk(clk), .rst(rst), .req(req), .lock(lock),
                                    .gnt(gnt0), .sel(sel0), .ack(ack0), .busy(busy0));
    alu_arb4 #(.LATENCY(3)) u_dut3 (.clk(clk), .rst(rst), .req(req), .lock(lock),
                                    .gnt(gnt3), .sel(sel3), .ack(ack3), .busy(busy3));

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end
    always @(posedge clk) cyc <= cyc + 1;

    // Model: owner index (-1 idle), cycles since grant, pointer, retained select.
    int m_own[2] = '{-1, -1};
    int m_t[2]   = '{0, 0};
    int m_ptr[2] = '{0, 0};
    int m_sel[2] = '{0, 0};

    function automatic int pick(input int p, input logic [3:0] r);
        for (int j = 0; j < 4; j++) if (r[(p + j) % 4]) return (p + j) % 4;
        return -1;
    endfunction

    task automatic mstep(input int k, input int lat);
        int w;
        if (rst) begin
            m_own[k] = -1; m_t[k] = 0; m_ptr[k] = 0; m_sel[k] = 0;
        end else if (m_own[k] < 0) begin
            w = pick(m_ptr[k], req);
            if (w >= 0) begin
                m_own[k] = w; m_t[k] = 1; m_sel[k] = w; m_ptr[k] = (w + 1) % 4;
            end
        end else if (m_t[k] <= lat) m_t[k] = m_t[k] + 1;
        else if (LOCK && lock[m_own[k]] && req[m_own[k]]) m_t[k] = 1;
        else m_own[k] = -1;
    endtask

    always @(posedge clk) begin
        mstep(0, 1);
        mstep(1, 3);
    end

    function automatic logic [3:0] eg(input int k);
        return (m_own[k] >= 0) ? 4'(1 << m_own[k]) : 4'b0;
    endfunction
    function automatic logic [3:0] ea(input int k, input int lat);
        return (m_own[k] >= 0 && m_t[k] == lat + 1) ? 4'(1 << m_own[k]) : 4'b0;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    endtask

    always @(negedge clk) begin
        if (mdl_on) begin
            chk("m1_gnt", 32'(gnt0), 32'(eg(0)));
            chk("m1_ack", 32'(ack0), 32'(ea(0, 1)));
            chk("m1_busy", 32'(busy0), 32'(m_own[0] >= 0));
            chk("m1_sel", 32'(sel0), 32'(m_sel[0]));
            chk("m3_gnt", 32'(gnt3), 32'(eg(1)));
            chk("m3_ack", 32'(ack3), 32'(ea(1, 3)));
            chk("m3_busy", 32'(busy3), 32'(m_own[1] >= 0));
            chk("m3_sel", 32'(sel3), 32'(m_sel[1]));
        end
    end

    task automatic tick;
        @(negedge clk);
    endtask

    function automatic int idx(input logic [3:0] v);
        for (int i = 0; i < 4; i++) if (v[i]) return i;
        return -1;
    endfunction

    task automatic do_reset;
        rst = 1'b1; req = '0; lock = '0; prev_ack = '0;
        tick; tick;
        rst = 1'b0;
        ord.delete(); cq.delete();
    endtask

    // Requesters hold req, dropping a bit for one cycle after its ack unless locked.
    task automatic run_acks(input logic [3:0] base, input int n, input int unlock_after);
        int got = 0, guard = 0;
        req = base & ~(prev_ack & ~lock);
        while (got < n && guard < 80) begin
            tick; guard++;
            req = base & ~(prev_ack & ~lock);
            prev_ack = ack0;
            if (ack0 != '0) begin
                ord.push_back(idx(ack0)); cq.push_back(cyc); got++;
                if (got == unlock_after) lock = '0;
            end
        end
        chk("ack_wait", 32'(got), 32'(n));
    endtask

    initial begin
        rst = 1'b1; req = 4'hF; lock = '0;
        // Reset held two cycles with all requests high.
        tick; mdl_on = 1;
        chk("rst_gnt", 32'(gnt0), 0); chk("rst_busy", 32'(busy0), 0);
        tick;
        chk("rst_gnt2", 32'(gnt0), 0); chk("rst_sel2", 32'(sel0), 0);
        chk("rst_ack2", 32'(ack0), 0); chk("rst_busy3", 32'(busy3), 0);

        // Single request, LATENCY=1.
        do_reset;
        req = 4'b0100; tick;
        chk("s_gnt_c1", 32'(gnt0), 32'h4); chk("s_sel_c1", 32'(sel0), 2);
        chk("s_ack_c1", 32'(ack0), 0);     chk("s_busy_c1", 32'(busy0), 1);
        tick;
        chk("s_gnt_c2", 32'(gnt0), 32'h4); chk("s_ack_c2", 32'(ack0), 32'h4);
        req = '0; tick;
        chk("s_busy_c3", 32'(busy0), 0); chk("s_gnt_c3", 32'(gnt0), 0);
        chk("s_ack_c3", 32'(ack0), 0);

        // Fairness with all four requesting.
        do_reset;
        run_acks(4'hF, 6, 0);
        for (int i = 0; i < 6; i++) if (i < ord.size()) chk("fair_order", 32'(ord[i]), 32'(exp_fair[i]));
        for (int i = 1; i < 6; i++) if (i < cq.size()) chk("fair_period", 32'(cq[i] - cq[i-1]), 3);

        // Pointer wrap: grant 1 leaves ptr=2, then 1010 must serve 3 before 1.
        do_reset;
        run_acks(4'b0010, 1, 0);
        run_acks(4'b1010, 2, 0);
        for (int i = 0; i < 3; i++) if (i < ord.size()) chk("wrap_order", 32'(ord[i]), 32'(exp_wrap[i]));

        // Reset in the second BUSY cycle of the LATENCY=3 instance.
        do_reset;
        req = 4'b0001; tick; tick;
        chk("mr_busy_c2", 32'(busy3), 1); chk("mr_ack_c2", 32'(ack3), 0);
        rst = 1'b1; tick;
        chk("mr_gnt", 32'(gnt3), 0); chk("mr_sel", 32'(sel3), 0);
        chk("mr_ack", 32'(ack3), 0); chk("mr_busy", 32'(busy3), 0);
        rst = 1'b0; req = 4'b0011; tick;
        chk("mr_regnt", 32'(gnt3), 32'h1); chk("mr_resel", 32'(sel3), 0);

        // Lock: requester 0 locked, requester 2 also waiting.
        do_reset;
        lock = 4'b0001;
        run_acks(4'b0101, NLK, 2);
        for (int i = 0; i < NLK; i++) if (i < ord.size()) chk("lock_order", 32'(ord[i]), 32'(exp_lock[i]));
        if (cq.size() >= 2) chk("lock_gap", 32'(cq[1] - cq[0]), 32'(LK_GAP));

        req = '0; lock = '0;
        repeat (6) tick;
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
